// File: rtl/segment_descriptor_loader.sv
// Purpose: loads one protected-mode segment register. It checks the selector, fetches the 8-byte descriptor,
//          applies the 386 type/privilege/presence rules, sets the accessed bit, and then commits or faults.
// Latency: the result pulse comes 2 cycles after accept for a selector fault or a null load, 5 cycles plus
//          memory waits for a full load, and one more memory access when the accessed bit must be set.
// Backpressure: only one load is in flight. o_load_ready is high only in IDLE. Each memory request holds
//          address and data until i_mem_ack.
//
// Ports:
//   i_clock, i_reset              clock, asynchronous active-high reset
//   i_load_valid / o_load_ready   load handshake; i_selector, i_seg_index, i_cpl latched at accept
//   i_gdtr_*, i_ldtr_*            descriptor table bases/limits, LDTR usability
//   o_mem_* / i_mem_*             32-bit descriptor memory port (req held until ack)
//   o_cache_*                     descriptor cache write, valid for the single COMMIT cycle
//   o_done / o_fault              completion pulses; o_fault_vector/o_fault_code valid with o_fault
module segment_descriptor_loader #(
    parameter int SEG_COUNT = 6,
    parameter int IDX_W     = 3
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_load_valid,
    output logic             o_load_ready,
    input  logic [15:0]      i_selector,
    input  logic [IDX_W-1:0] i_seg_index,
    input  logic [1:0]       i_cpl,
    input  logic [31:0]      i_gdtr_base,
    input  logic [15:0]      i_gdtr_limit,
    input  logic [31:0]      i_ldtr_base,
    input  logic [15:0]      i_ldtr_limit,
    input  logic             i_ldtr_valid,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic [31:0]      o_mem_addr,
    output logic [31:0]      o_mem_wdata,
    input  logic             i_mem_ack,
    input  logic [31:0]      i_mem_rdata,
    output logic             o_cache_we,
    output logic [IDX_W-1:0] o_cache_index,
    output logic             o_cache_valid,
    output logic [15:0]      o_cache_selector,
    output logic [63:0]      o_cache_descriptor,
    output logic             o_done,
    output logic             o_fault,
    output logic [7:0]       o_fault_vector,
    output logic [15:0]      o_fault_code
);

    localparam logic [7:0] VEC_GP = 8'd13;
    localparam logic [7:0] VEC_NP = 8'd11;
    localparam logic [7:0] VEC_SS = 8'd12;

    localparam logic [IDX_W-1:0] IDX_CS = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_SS = IDX_W'(2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHK_SEL,
        S_RD0,
        S_RD1,
        S_CHK_DESC,
        S_WR_ACC,
        S_COMMIT,
        S_FAULT
    } state_t;

    // Access-rights byte of the descriptor (bits 47:40 of the architectural descriptor,
    // which land in desc[15:8] because the upper dword sits in the low half of the cache layout).
    typedef struct packed {
        logic       present;
        logic [1:0] dpl;
        logic       s;
        logic       code;
        logic       conf_exp;   // conforming (code) / expand-down (data)
        logic       rd_wr;      // readable (code) / writable (data)
        logic       accessed;
    } access_t;

    function automatic access_t segment_descriptor_decode(input logic [7:0] ab);
        access_t f;
        f.present  = ab[7];
        f.dpl      = ab[6:5];
        f.s        = ab[4];
        f.code     = ab[3];
        f.conf_exp = ab[2];
        f.rd_wr    = ab[1];
        f.accessed = ab[0];
        return f;
    endfunction

    state_t           state_q;
    state_t           state_d;
    logic [15:0]      sel_q;
    logic [IDX_W-1:0] idx_q;
    logic [1:0]       cpl_q;
    logic [31:0]      desc_addr_q;
    logic [63:0]      desc_q;
    logic             null_q;
    logic [7:0]       fault_vec_q;

    // Selector-check terms, evaluated while in CHK_SEL.
    logic             sel_null;
    logic             sel_fault;
    logic [31:0]      tbl_base;
    logic [15:0]      tbl_limit;
    logic [15:0]      sel_top;

    // Descriptor-check terms, evaluated while in CHK_DESC.
    access_t          acc;
    logic [1:0]       rpl;
    logic [1:0]       max_pl;
    logic             desc_fault;
    logic [7:0]       desc_vec;
    logic [31:0]      desc_addr_hi;

    assign desc_addr_hi = desc_addr_q + 32'd4;

    always_comb begin
        sel_null  = (sel_q[15:2] == 14'd0);
        tbl_base  = sel_q[2] ? i_ldtr_base  : i_gdtr_base;
        tbl_limit = sel_q[2] ? i_ldtr_limit : i_gdtr_limit;
        sel_top   = {sel_q[15:3], 3'b111};
        sel_fault = 1'b0;
        if (int'(idx_q) >= SEG_COUNT) begin
            sel_fault = 1'b1;
        end else if (sel_null) begin
            // A null selector is only legal for the data segment registers.
            sel_fault = (idx_q == IDX_CS) || (idx_q == IDX_SS);
        end else if (sel_q[2] && !i_ldtr_valid) begin
            sel_fault = 1'b1;
        end else if (sel_top > tbl_limit) begin
            sel_fault = 1'b1;
        end
    end

    always_comb begin
        acc        = segment_descriptor_decode(desc_q[15:8]);
        rpl        = sel_q[1:0];
        max_pl     = (cpl_q > rpl) ? cpl_q : rpl;
        desc_fault = 1'b1;
        desc_vec   = VEC_GP;
        if (!acc.s) begin
            desc_fault = 1'b1;
        end else if (idx_q == IDX_SS) begin
            if (acc.code || !acc.rd_wr || rpl != cpl_q || acc.dpl != cpl_q) begin
                desc_fault = 1'b1;
            end else if (!acc.present) begin
                desc_vec = VEC_SS;
            end else begin
                desc_fault = 1'b0;
            end
        end else if (idx_q == IDX_CS) begin
            if (!acc.code) begin
                desc_fault = 1'b1;
            end else if (acc.conf_exp ? (acc.dpl > cpl_q) : (acc.dpl != cpl_q)) begin
                desc_fault = 1'b1;
            end else if (!acc.present) begin
                desc_vec = VEC_NP;
            end else begin
                desc_fault = 1'b0;
            end
        end else begin
            // Conforming readable code skips the privilege test for data segment registers.
            if (acc.code && !acc.rd_wr) begin
                desc_fault = 1'b1;
            end else if ((!acc.code || !acc.conf_exp) && (acc.dpl < max_pl)) begin
                desc_fault = 1'b1;
            end else if (!acc.present) begin
                desc_vec = VEC_NP;
            end else begin
                desc_fault = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            sel_q       <= 16'h0;
            idx_q       <= '0;
            cpl_q       <= 2'd0;
            desc_addr_q <= 32'h0;
            desc_q      <= 64'h0;
            null_q      <= 1'b0;
            fault_vec_q <= 8'h0;
        end else begin
            if (state_q == S_IDLE && i_load_valid) begin
                sel_q  <= i_selector;
                idx_q  <= i_seg_index;
                cpl_q  <= i_cpl;
                null_q <= 1'b0;
            end
            if (state_q == S_CHK_SEL) begin
                // The table base is captured so that a base change mid-load cannot move the request.
                desc_addr_q <= tbl_base + {16'h0, sel_q[15:3], 3'b000};
                null_q      <= sel_null;
                fault_vec_q <= VEC_GP;
            end
            if (state_q == S_RD0 && i_mem_ack) begin
                desc_q[63:32] <= i_mem_rdata;
            end
            if (state_q == S_RD1 && i_mem_ack) begin
                desc_q[31:0] <= i_mem_rdata;
            end
            if (state_q == S_CHK_DESC) begin
                fault_vec_q <= desc_vec;
            end
        end
    end

    always_comb begin
        state_d            = state_q;
        o_load_ready       = 1'b0;
        o_mem_req          = 1'b0;
        o_mem_we           = 1'b0;
        o_mem_addr         = 32'h0;
        o_mem_wdata        = 32'h0;
        o_cache_we         = 1'b0;
        o_cache_index      = '0;
        o_cache_valid      = 1'b0;
        o_cache_selector   = 16'h0;
        o_cache_descriptor = 64'h0;
        o_done             = 1'b0;
        o_fault            = 1'b0;
        o_fault_vector     = 8'h0;
        o_fault_code       = 16'h0;
        case (state_q)
            S_IDLE: begin
                o_load_ready = 1'b1;
                if (i_load_valid) begin
                    state_d = S_CHK_SEL;
                end
            end
            S_CHK_SEL: begin
                if (sel_fault) begin
                    state_d = S_FAULT;
                end else if (sel_null) begin
                    state_d = S_COMMIT;
                end else begin
                    state_d = S_RD0;
                end
            end
            S_RD0: begin
                o_mem_req  = 1'b1;
                o_mem_addr = desc_addr_q;
                if (i_mem_ack) begin
                    state_d = S_RD1;
                end
            end
            S_RD1: begin
                o_mem_req  = 1'b1;
                o_mem_addr = desc_addr_hi;
                if (i_mem_ack) begin
                    state_d = S_CHK_DESC;
                end
            end
            S_CHK_DESC: begin
                if (desc_fault) begin
                    state_d = S_FAULT;
                end else if (!acc.accessed) begin
                    state_d = S_WR_ACC;
                end else begin
                    state_d = S_COMMIT;
                end
            end
            S_WR_ACC: begin
                o_mem_req   = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_addr  = desc_addr_hi;
                o_mem_wdata = {desc_q[31:9], 1'b1, desc_q[7:0]};
                if (i_mem_ack) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                o_cache_we       = 1'b1;
                o_done           = 1'b1;
                o_cache_index    = idx_q;
                o_cache_valid    = !null_q;
                o_cache_selector = sel_q;
                // A committed descriptor always has A=1: it was either already set or just written back.
                o_cache_descriptor = null_q ? 64'h0 : {desc_q[63:9], 1'b1, desc_q[7:0]};
                state_d          = S_IDLE;
            end
            S_FAULT: begin
                o_fault        = 1'b1;
                o_fault_vector = fault_vec_q;
                o_fault_code   = {sel_q[15:2], 2'b00};
                state_d        = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_segment_descriptor_loader.sv
// Purpose: self-checking bench for segment_descriptor_loader. It runs directed loads and then randomized loads.
// Latency: results are checked on the pulse cycle, and memory transactions are compared after each load.
// Backpressure: the memory responder holds its ack for a random or fixed number of cycles per access.
module tb_segment_descriptor_loader;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_load_valid;
    logic        o_load_ready;
    logic [15:0] i_selector;
    logic [2:0]  i_seg_index;
    logic [1:0]  i_cpl;
    logic [31:0] i_gdtr_base;
    logic [15:0] i_gdtr_limit;
    logic [31:0] i_ldtr_base;
    logic [15:0] i_ldtr_limit;
    logic        i_ldtr_valid;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic        o_cache_we;
    logic [2:0]  o_cache_index;
    logic        o_cache_valid;
    logic [15:0] o_cache_selector;
    logic [63:0] o_cache_descriptor;
    logic        o_done;
    logic        o_fault;
    logic [7:0]  o_fault_vector;
    logic [15:0] o_fault_code;

    segment_descriptor_loader dut (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_load_valid(i_load_valid), .o_load_ready(o_load_ready),
        .i_selector(i_selector), .i_seg_index(i_seg_index), .i_cpl(i_cpl),
        .i_gdtr_base(i_gdtr_base), .i_gdtr_limit(i_gdtr_limit),
        .i_ldtr_base(i_ldtr_base), .i_ldtr_limit(i_ldtr_limit), .i_ldtr_valid(i_ldtr_valid),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
        .o_cache_we(o_cache_we), .o_cache_index(o_cache_index), .o_cache_valid(o_cache_valid),
        .o_cache_selector(o_cache_selector), .o_cache_descriptor(o_cache_descriptor),
        .o_done(o_done), .o_fault(o_fault), .o_fault_vector(o_fault_vector), .o_fault_code(o_fault_code)
    );

    always #5 i_clock = ~i_clock;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } tx_t;

    logic [31:0] mem [logic [31:0]];
    tx_t exp_tx[$];
    tx_t got_tx[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    // Expected outcome of the current load, filled by the model.
    logic        exp_fault;
    logic [7:0]  exp_vec;
    logic [15:0] exp_code;
    logic        exp_cvalid;
    logic [63:0] exp_desc;
    logic [15:0] exp_sel;
    logic [2:0]  exp_idx;

    bit result_seen = 0;
    bit expect_none = 0;
    int fixed_delay = -1;

    logic        last_done, last_fault, last_cvalid;
    logic [7:0]  last_vec;
    logic [15:0] last_code;
    logic [63:0] last_desc;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] tx_addr(input int i);
        return (got_tx.size() > i) ? got_tx[i].addr : 32'hDEAD_BEEF;
    endfunction

    // Reference outcome of a load, applying the architectural rules in order with early exits.
    function automatic void model(input logic [15:0] sel, input logic [2:0] idx, input logic [1:0] cpl);
        logic [31:0] base, a0, lo, hi;
        logic [15:0] lim;
        logic [7:0]  ab;
        logic [1:0]  rpl, dpl, hipl;
        exp_tx.delete();
        exp_sel    = sel;
        exp_idx    = idx;
        exp_fault  = 1'b1;
        exp_vec    = 8'd13;
        exp_code   = {sel[15:2], 2'b00};
        exp_cvalid = 1'b1;
        exp_desc   = 64'h0;
        if (idx >= 3'd6) return;
        if (sel[15:2] == 14'd0) begin
            if (idx == 3'd1 || idx == 3'd2) return;
            exp_fault  = 1'b0;
            exp_cvalid = 1'b0;
            return;
        end
        if (sel[2] && !i_ldtr_valid) return;
        base = sel[2] ? i_ldtr_base : i_gdtr_base;
        lim  = sel[2] ? i_ldtr_limit : i_gdtr_limit;
        if ((sel | 16'h0007) > lim) return;
        a0 = base + {16'h0, sel & 16'hFFF8};
        lo = rd(a0);
        hi = rd(a0 + 32'd4);
        exp_tx.push_back({1'b0, a0, 32'h0});
        exp_tx.push_back({1'b0, a0 + 32'd4, 32'h0});
        ab   = hi[15:8];
        rpl  = sel[1:0];
        dpl  = ab[6:5];
        hipl = (cpl > rpl) ? cpl : rpl;
        if (!ab[4]) return;
        if (idx == 3'd2) begin
            if (ab[3] || !ab[1] || rpl != cpl || dpl != cpl) return;
            if (!ab[7]) begin exp_vec = 8'd12; return; end
        end else if (idx == 3'd1) begin
            if (!ab[3]) return;
            if (ab[2] ? (dpl > cpl) : (dpl != cpl)) return;
            if (!ab[7]) begin exp_vec = 8'd11; return; end
        end else begin
            if (ab[3] && !ab[1]) return;
            if ((!ab[3] || !ab[2]) && dpl < hipl) return;
            if (!ab[7]) begin exp_vec = 8'd11; return; end
        end
        if (!ab[0]) exp_tx.push_back({1'b1, a0 + 32'd4, hi | 32'h100});
        exp_fault = 1'b0;
        exp_desc  = {lo, hi | 32'h100};
    endfunction

    // Memory responder: one access at a time, ack after a number of wait cycles, address must hold.
    logic        in_txn = 1'b0;
    logic        t_we;
    logic [31:0] t_addr, t_wdata;
    int          wait_left;
    initial begin
        i_mem_ack   = 1'b0;
        i_mem_rdata = 32'h0;
        forever begin
            @(posedge i_clock); #1;
            i_mem_ack   = 1'b0;
            i_mem_rdata = 32'h0;
            if (i_reset) begin
                in_txn = 1'b0;
            end else if (o_mem_req) begin
                if (!in_txn) begin
                    in_txn    = 1'b1;
                    t_we      = o_mem_we;
                    t_addr    = o_mem_addr;
                    t_wdata   = o_mem_wdata;
                    wait_left = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
                end else begin
                    check("mem_hold", 96'({o_mem_we, o_mem_addr, o_mem_wdata}), 96'({t_we, t_addr, t_wdata}));
                end
                if (wait_left == 0) begin
                    i_mem_ack = 1'b1;
                    if (t_we) mem[t_addr] = t_wdata;
                    else i_mem_rdata = rd(t_addr);
                    got_tx.push_back({t_we, t_addr, t_we ? t_wdata : 32'h0});
                    in_txn = 1'b0;
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // Compare process: checks the result outputs against the model on every pulse cycle.
    initial begin
        forever begin
            @(posedge i_clock); #1;
            if (!i_reset) begin
                if (!o_mem_req) check("mem_idle", 96'({o_mem_we, o_mem_addr, o_mem_wdata}), 96'(0));
                if (o_done || o_fault) begin
                    last_done   = o_done;
                    last_fault  = o_fault;
                    last_vec    = o_fault_vector;
                    last_code   = o_fault_code;
                    last_cvalid = o_cache_valid;
                    last_desc   = o_cache_descriptor;
                    if (expect_none) begin
                        check("stray_pulse", 96'({o_done, o_fault}), 96'(0));
                    end else begin
                        check("result", 96'({o_done, o_fault, o_cache_we}), 96'(exp_fault ? 3'b010 : 3'b101));
                        if (exp_fault) begin
                            check("fault_vector", 96'(o_fault_vector), 96'(exp_vec));
                            check("fault_code", 96'(o_fault_code), 96'(exp_code));
                        end else begin
                            check("cache_index", 96'(o_cache_index), 96'(exp_idx));
                            check("cache_selector", 96'(o_cache_selector), 96'(exp_sel));
                            check("cache_valid", 96'(o_cache_valid), 96'(exp_cvalid));
                            if (exp_cvalid) check("cache_desc", 96'(o_cache_descriptor), 96'(exp_desc));
                        end
                    end
                    result_seen = 1;
                end else if (o_cache_we) begin
                    check("cache_we_alone", 96'(o_cache_we), 96'(0));
                end
            end
        end
    end

    task automatic run_load(input logic [15:0] sel, input logic [2:0] idx, input logic [1:0] cpl);
        model(sel, idx, cpl);
        got_tx.delete();
        result_seen = 0;
        last_done   = 1'b0;
        last_fault  = 1'b0;
        @(negedge i_clock);
        check("ready_idle", 96'(o_load_ready), 96'(1));
        i_load_valid = 1'b1;
        i_selector   = sel;
        i_seg_index  = idx;
        i_cpl        = cpl;
        @(posedge i_clock); #2;
        i_load_valid = 1'b0;
        check("ready_busy", 96'(o_load_ready), 96'(0));
        for (int c = 0; c < 200 && !result_seen; c++) begin
            @(posedge i_clock); #2;
        end
        check("load_finished", 96'(result_seen), 96'(1));
        check("tx_count", 96'(got_tx.size()), 96'(exp_tx.size()));
        for (int i = 0; i < exp_tx.size() && i < got_tx.size(); i++)
            check($sformatf("tx%0d", i), 96'(got_tx[i]), 96'(exp_tx[i]));
        @(posedge i_clock); #2;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        i_reset      = 1'b1;
        i_load_valid = 1'b0;
        i_selector   = 16'h0;
        i_seg_index  = 3'd0;
        i_cpl        = 2'd0;
        i_gdtr_base  = 32'h1000;
        i_gdtr_limit = 16'h001F;
        i_ldtr_base  = 32'h2000;
        i_ldtr_limit = 16'h001F;
        i_ldtr_valid = 1'b0;

        repeat (2) @(posedge i_clock);
        #1;
        check("reset_ready", 96'(o_load_ready), 96'(1));
        check("reset_outs", 96'({o_mem_req, o_done, o_fault, o_cache_we, o_fault_vector}), 96'(0));
        @(negedge i_clock);
        i_reset = 1'b0;

        // Present, accessed, writable data descriptor at GDT entry 2.
        mem[32'h1010] = 32'h0000FFFF;
        mem[32'h1014] = 32'h00CF9300;
        run_load(16'h0010, 3'd3, 2'd0);
        check("t1_model_desc", 96'(exp_desc), 96'(64'h0000FFFF_00CF9300));
        check("t1_done", 96'(last_done), 96'(1));
        check("t1_desc", 96'(last_desc), 96'(64'h0000FFFF_00CF9300));
        check("t1_addr0", 96'(tx_addr(0)), 96'(32'h1010));
        check("t1_addr1", 96'(tx_addr(1)), 96'(32'h1014));
        check("t1_ntx", 96'(got_tx.size()), 96'(2));

        // Same load with the accessed bit clear: one extra write-back.
        mem[32'h1014] = 32'h00CF9200;
        run_load(16'h0010, 3'd3, 2'd0);
        check("t2_ntx", 96'(got_tx.size()), 96'(3));
        check("t2_wr", 96'((got_tx.size() > 2) ? got_tx[2] : '0), 96'({1'b1, 32'h1014, 32'h00CF9300}));
        check("t2_mem", 96'(mem[32'h1014]), 96'(32'h00CF9300));
        check("t2_desc", 96'(last_desc), 96'(64'h0000FFFF_00CF9300));

        // Null selectors.
        run_load(16'h0000, 3'd2, 2'd0);
        check("t3_ss_null", 96'({last_fault, last_vec, last_code}), 96'({1'b1, 8'd13, 16'h0000}));
        check("t3_no_mem", 96'(got_tx.size()), 96'(0));
        run_load(16'h0003, 3'd3, 2'd0);
        check("t3_ds_null", 96'({last_done, last_cvalid}), 96'(2'b10));

        // Limit and privilege faults.
        run_load(16'h0020, 3'd3, 2'd0);
        check("t4_limit", 96'({last_fault, last_vec, last_code}), 96'({1'b1, 8'd13, 16'h0020}));
        run_load(16'h0013, 3'd2, 2'd0);
        check("t4_ss_rpl", 96'({last_fault, last_vec, last_code}), 96'({1'b1, 8'd13, 16'h0010}));

        // Not-present descriptor at GDT entry 3.
        mem[32'h1018] = 32'h0000FFFF;
        mem[32'h101C] = 32'h00CF1300;
        run_load(16'h0018, 3'd3, 2'd0);
        check("t5_np", 96'({last_fault, last_vec}), 96'({1'b1, 8'd11}));
        run_load(16'h0018, 3'd2, 2'd0);
        check("t5_ss", 96'({last_fault, last_vec}), 96'({1'b1, 8'd12}));

        // Slow memory: address must hold across the wait cycles.
        fixed_delay = 5;
        run_load(16'h0010, 3'd0, 2'd0);
        check("t6_slow_done", 96'(last_done), 96'(1));

        // Reset during the second read.
        fixed_delay = 8;
        model(16'h0010, 3'd3, 2'd0);
        expect_none = 1;
        result_seen = 0;
        got_tx.delete();
        @(negedge i_clock);
        i_load_valid = 1'b1;
        i_selector   = 16'h0010;
        i_seg_index  = 3'd3;
        i_cpl        = 2'd0;
        @(posedge i_clock); #2;
        i_load_valid = 1'b0;
        for (int c = 0; c < 100 && got_tx.size() < 1; c++) begin
            @(posedge i_clock); #2;
        end
        @(posedge i_clock); #2;
        check("t7_rd1_req", 96'({o_mem_req, o_mem_addr}), 96'({1'b1, 32'h1014}));
        #1 i_reset = 1'b1;
        #1;
        check("t7_req_drop", 96'(o_mem_req), 96'(0));
        repeat (2) @(posedge i_clock);
        @(negedge i_clock);
        i_reset = 1'b0;
        repeat (5) begin
            @(posedge i_clock); #2;
        end
        check("t7_no_pulse", 96'(result_seen), 96'(0));
        expect_none = 0;
        fixed_delay = -1;
        run_load(16'h0010, 3'd3, 2'd0);
        check("t7_next_done", 96'(last_done), 96'(1));

        // Randomized loads against the model.
        for (int n = 0; n < 300; n++) begin
            logic [15:0] sel;
            logic [2:0]  idx;
            logic [1:0]  cpl, rpl, dpl;
            logic [12:0] ent;
            logic        ti;
            logic [31:0] a0, hi;
            i_gdtr_base  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFF8);
            i_gdtr_limit = 16'($urandom_range(1, 8) * 8 - 1);
            i_ldtr_base  = $urandom & 32'hFFFF_FFF8;
            i_ldtr_limit = 16'($urandom_range(1, 8) * 8 - 1);
            i_ldtr_valid = ($urandom_range(0, 4) != 0);
            ti  = 1'($urandom_range(0, 1));
            cpl = 2'($urandom_range(0, 3));
            rpl = 2'($urandom_range(0, 3));
            dpl = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                rpl = cpl;
                dpl = cpl;
            end
            ent = 13'($urandom_range(0, 9));
            sel = ($urandom_range(0, 9) == 0) ? {14'h0, rpl} : {ent, ti, rpl};
            idx = 3'($urandom_range(0, 6));
            a0  = (ti ? i_ldtr_base : i_gdtr_base) + {16'h0, ent, 3'b000};
            hi  = $urandom;
            hi[15:8] = {($urandom_range(0, 5) != 0), dpl, ($urandom_range(0, 5) != 0), 4'($urandom_range(0, 15))};
            mem[a0] = $urandom;
            mem[a0 + 32'd4] = hi;
            run_load(sel, idx, cpl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
